// File: rtl/layer_ctrl_if.sv
// Input-vector and result streams of layer_ctrl.
// The layer_ctrl side uses slave; the feeding/consuming side uses master.
interface layer_ctrl_if #(
   parameter int WIDTH = 32,
   parameter int IDX_W = 2
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a1;
   logic [WIDTH-1:0] in_a2;
   logic [WIDTH-1:0] in_a3;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_y;
   logic [IDX_W-1:0] out_idx;
   logic             out_last;

   modport master (
      output in_valid, in_a1, in_a2, in_a3, out_ready,
      input  in_ready, out_valid, out_y, out_idx, out_last
   );

   modport slave (
      input  in_valid, in_a1, in_a2, in_a3, out_ready,
      output in_ready, out_valid, out_y, out_idx, out_last
   );
endinterface

// File: rtl/layer_ctrl.sv
// Sequencer that time-multiplexes one neuron across a fully connected 3-input layer.
// It owns the weight/bias file, latches the input vector and emits one result per neuron.
module layer_ctrl #(
   parameter int WIDTH    = 32,
   parameter int N_NEURON = 4,
   parameter int IDX_W    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [IDX_W+1:0] cfg_addr,
   input  logic [WIDTH-1:0] cfg_data,
   layer_ctrl_if.slave      io,
   output logic [WIDTH-1:0] n_a1,
   output logic [WIDTH-1:0] n_a2,
   output logic [WIDTH-1:0] n_a3,
   output logic [WIDTH-1:0] n_w1,
   output logic [WIDTH-1:0] n_w2,
   output logic [WIDTH-1:0] n_w3,
   output logic [WIDTH-1:0] n_b,
   input  logic [WIDTH-1:0] n_y
);
   typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURON - 1);

   state_t           state, state_nxt;
   logic [IDX_W-1:0] idx;
   logic [WIDTH-1:0] act1, act2, act3;
   logic [WIDTH-1:0] wf [N_NEURON][4];
   logic [WIDTH-1:0] y_q;
   logic [IDX_W-1:0] idx_q;
   logic             last_q;

   logic             accept, capture, advance, cfg_take;
   logic [IDX_W-1:0] cfg_n;

   assign cfg_n = cfg_addr[IDX_W+1:2];

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (io.in_valid)  state_nxt = RUN;
         RUN:                    state_nxt = OUT;
         OUT:  if (io.out_ready) state_nxt = last_q ? IDLE : RUN;
         default:                state_nxt = IDLE;
      endcase
   end

   always_comb begin
      io.in_ready  = (state == IDLE);
      io.out_valid = (state == OUT);
      accept       = (state == IDLE) && io.in_valid;
      capture      = (state == RUN);
      advance      = (state == OUT) && io.out_ready && !last_q;
      cfg_take     = (state == IDLE) && cfg_we && (32'(cfg_n) < 32'(N_NEURON));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx    <= '0;
         act1   <= '0;
         act2   <= '0;
         act3   <= '0;
         y_q    <= '0;
         idx_q  <= '0;
         last_q <= 1'b0;
         for (int unsigned i = 0; i < N_NEURON; i++)
            for (int unsigned j = 0; j < 4; j++)
               wf[i][j] <= '0;
      end else begin
         if (accept) begin
            idx  <= '0;
            act1 <= io.in_a1;
            act2 <= io.in_a2;
            act3 <= io.in_a3;
         end
         if (capture) begin
            y_q    <= n_y;
            idx_q  <= idx;
            last_q <= (idx == LAST_IDX);
         end
         if (advance)  idx <= idx + 1'b1;
         // an IDLE write lands before the RUN cycle that reads it, even when it coincides with accept
         if (cfg_take) wf[cfg_n][cfg_addr[1:0]] <= cfg_data;
      end
   end

   assign io.out_y    = y_q;
   assign io.out_idx  = idx_q;
   assign io.out_last = last_q;

   assign n_a1 = act1;
   assign n_a2 = act2;
   assign n_a3 = act3;
   assign n_w1 = wf[idx][0];
   assign n_w2 = wf[idx][1];
   assign n_w3 = wf[idx][2];
   assign n_b  = wf[idx][3];
endmodule

// File: tb/tb_layer_ctrl.sv
// Self-checking bench for layer_ctrl: vector table, hand-written corner sequences,
// and randomized layers checked against a weight-file model.
module tb_layer_ctrl;
   localparam int W = 32;
   localparam int N = 4;
   localparam int BOUND = 200;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          cfg_we;
   logic [3:0]    cfg_addr;
   logic [W-1:0]  cfg_data;
   logic [W-1:0]  n_a1, n_a2, n_a3, n_w1, n_w2, n_w3, n_b, n_y;

   logic          cfg_we3;
   logic [3:0]    cfg_addr3;
   logic [W-1:0]  cfg_data3;
   logic [W-1:0]  m_a1, m_a2, m_a3, m_w1, m_w2, m_w3, m_b, m_y;

   layer_ctrl_if #(.WIDTH(W), .IDX_W(2)) bif ();
   layer_ctrl_if #(.WIDTH(W), .IDX_W(2)) bif3 ();

   // neuron stubs
   assign n_y = n_w1 + n_w2 + n_w3 + n_b;
   assign m_y = m_w1 + m_w2 + m_w3 + m_b;

   layer_ctrl #(.WIDTH(W), .N_NEURON(N), .IDX_W(2)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .io(bif.slave), .n_a1(n_a1), .n_a2(n_a2), .n_a3(n_a3),
      .n_w1(n_w1), .n_w2(n_w2), .n_w3(n_w3), .n_b(n_b), .n_y(n_y)
   );

   layer_ctrl #(.WIDTH(W), .N_NEURON(3), .IDX_W(2)) dut3 (
      .clk(clk), .rst(rst), .cfg_we(cfg_we3), .cfg_addr(cfg_addr3), .cfg_data(cfg_data3),
      .io(bif3.slave), .n_a1(m_a1), .n_a2(m_a2), .n_a3(m_a3),
      .n_w1(m_w1), .n_w2(m_w2), .n_w3(m_w3), .n_b(m_b), .n_y(m_y)
   );

   int checks = 0;
   int errors = 0;

   logic [W-1:0] wm [N][4];
   logic [W-1:0] exp_y [N];

   typedef struct packed {
      logic [31:0] wn;
      logic [31:0] ws;
      logic [W-1:0] wd;
      logic [W-1:0] a1;
      logic [W-1:0] a2;
      logic [W-1:0] a3;
      logic [W-1:0] y0;
      logic [W-1:0] y1;
      logic [W-1:0] y2;
      logic [W-1:0] y3;
   } vec_t;

   vec_t vt [5];

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int n, input int s, input logic [W-1:0] d, input bit take);
      cfg_we   = 1'b1;
      cfg_addr = 4'(n * 4 + s);
      cfg_data = d;
      cyc();
      cfg_we   = 1'b0;
      if (take) wm[n][s] = d;
   endtask

   task automatic model_exp();
      for (int i = 0; i < N; i++)
         exp_y[i] = wm[i][0] + wm[i][1] + wm[i][2] + wm[i][3];
   endtask

   task automatic run_layer(input logic [W-1:0] a1, input logic [W-1:0] a2, input logic [W-1:0] a3,
                            input int stall_idx, input int stall_len,
                            input bit rnd, input bit timing, input bit mid_wr);
      int got, cnt, st;
      bit r;
      got = 0; cnt = 0; st = 0;
      check("idle_in_ready", 64'(bif.in_ready), 64'd1);
      bif.in_valid = 1'b1;
      bif.in_a1 = a1; bif.in_a2 = a2; bif.in_a3 = a3;
      cyc();
      bif.in_valid = 1'b0;
      bif.in_a1 = '0; bif.in_a2 = '0; bif.in_a3 = '0;
      check("run_in_ready", 64'(bif.in_ready), 64'd0);
      check("first_latency", 64'(bif.out_valid), 64'd0);
      while (got < N && cnt < BOUND) begin
         if (mid_wr && cnt < 4) begin
            cfg_we = 1'b1; cfg_addr = 4'(2 * 4 + 3); cfg_data = 32'd99;
         end else begin
            cfg_we = 1'b0;
         end
         if (bif.out_valid) begin
            check("out_idx", 64'(bif.out_idx), 64'(got));
            check("out_y", 64'(bif.out_y), 64'(exp_y[got]));
            check("out_last", 64'(bif.out_last), 64'(got == N - 1));
            check("n_a1", 64'(n_a1), 64'(a1));
            check("n_a2", 64'(n_a2), 64'(a2));
            check("n_a3", 64'(n_a3), 64'(a3));
            if (got == stall_idx && st < stall_len) begin
               r = 1'b0;
               st++;
            end else begin
               r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            bif.out_ready = r;
            cyc();
            cnt++;
            if (r) got++;
            else check("hold_valid", 64'(bif.out_valid), 64'd1);
         end else begin
            bif.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc();
            cnt++;
         end
      end
      cfg_we = 1'b0;
      bif.out_ready = 1'b0;
      if (cnt >= BOUND) check("layer_timeout", 64'(got), 64'(N));
      if (timing) check("layer_cycles", 64'(cnt), 64'(2 * N));
      check("end_in_ready", 64'(bif.in_ready), 64'd1);
      check("end_out_valid", 64'(bif.out_valid), 64'd0);
   endtask

   function automatic vec_t mk(int wn, int ws, logic [W-1:0] wd, logic [W-1:0] a1, logic [W-1:0] a2,
                               logic [W-1:0] a3, logic [W-1:0] y0, logic [W-1:0] y1,
                               logic [W-1:0] y2, logic [W-1:0] y3);
      vec_t v;
      v.wn = 32'(wn); v.ws = 32'(ws); v.wd = wd;
      v.a1 = a1; v.a2 = a2; v.a3 = a3;
      v.y0 = y0; v.y1 = y1; v.y2 = y2; v.y3 = y3;
      return v;
   endfunction

   initial begin
      int got3, n3;
      rst = 1'b1;
      cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      cfg_we3 = 1'b0; cfg_addr3 = '0; cfg_data3 = '0;
      bif.in_valid = 1'b0; bif.in_a1 = '0; bif.in_a2 = '0; bif.in_a3 = '0; bif.out_ready = 1'b0;
      bif3.in_valid = 1'b0; bif3.in_a1 = '0; bif3.in_a2 = '0; bif3.in_a3 = '0; bif3.out_ready = 1'b0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < 4; j++)
            wm[i][j] = '0;

      // reset, with a write during the reset cycle that must be lost
      cyc();
      wr(0, 3, 32'd55, 1'b0);
      rst = 1'b0;
      check("rst_in_ready", 64'(bif.in_ready), 64'd1);
      check("rst_out_valid", 64'(bif.out_valid), 64'd0);
      check("rst_out_y", 64'(bif.out_y), 64'd0);
      check("rst_out_idx", 64'(bif.out_idx), 64'd0);
      check("rst_out_last", 64'(bif.out_last), 64'd0);
      check("rst_n_w1", 64'(n_w1), 64'd0);
      check("rst_n_w2", 64'(n_w2), 64'd0);
      check("rst_n_w3", 64'(n_w3), 64'd0);
      check("rst_n_b", 64'(n_b), 64'd0);
      check("rst_n_a1", 64'(n_a1), 64'd0);

      // vector table: one config write then one layer per record
      vt[0] = mk(0, 0, 32'd1, 32'd5, 32'd6, 32'd7, 32'd1, 32'd0, 32'd0, 32'd0);
      vt[1] = mk(0, 1, 32'd2, 32'd1, 32'd2, 32'd3, 32'd3, 32'd0, 32'd0, 32'd0);
      vt[2] = mk(0, 2, 32'd3, -32'sd1, 32'd0, 32'h7fffffff, 32'd6, 32'd0, 32'd0, 32'd0);
      vt[3] = mk(0, 3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd10, 32'd0, 32'd0, 32'd0);
      vt[4] = mk(3, 3, -32'sd7, 32'd5, 32'd6, 32'd7, 32'd10, 32'd0, 32'd0, -32'sd7);
      for (int k = 0; k < 5; k++) begin
         wr(int'(vt[k].wn), int'(vt[k].ws), vt[k].wd, 1'b1);
         exp_y[0] = vt[k].y0; exp_y[1] = vt[k].y1; exp_y[2] = vt[k].y2; exp_y[3] = vt[k].y3;
         run_layer(vt[k].a1, vt[k].a2, vt[k].a3, -1, 0, 1'b0, 1'b1, 1'b0);
      end

      // back-pressure on the neuron-1 result
      run_layer(32'd5, 32'd6, 32'd7, 1, 5, 1'b0, 1'b0, 1'b0);

      // writes during RUN/OUT are dropped; the same write in IDLE is used by the next layer
      run_layer(32'd5, 32'd6, 32'd7, -1, 0, 1'b0, 1'b1, 1'b1);
      wr(2, 3, 32'd99, 1'b1);
      model_exp();
      check("model_y2", 64'(exp_y[2]), 64'd99);
      run_layer(32'd5, 32'd6, 32'd7, -1, 0, 1'b0, 1'b1, 1'b0);

      // reset while holding the neuron-1 result
      bif.out_ready = 1'b0;
      bif.in_valid = 1'b1; bif.in_a1 = 32'd9; bif.in_a2 = 32'd9; bif.in_a3 = 32'd9;
      cyc();
      bif.in_valid = 1'b0;
      cyc();
      check("abort_idx0", 64'(bif.out_idx), 64'd0);
      bif.out_ready = 1'b1;
      cyc();
      bif.out_ready = 1'b0;
      cyc();
      check("abort_pre_valid", 64'(bif.out_valid), 64'd1);
      check("abort_pre_idx", 64'(bif.out_idx), 64'd1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("abort_out_valid", 64'(bif.out_valid), 64'd0);
      check("abort_in_ready", 64'(bif.in_ready), 64'd1);
      check("abort_n_w1", 64'(n_w1), 64'd0);
      check("abort_n_w2", 64'(n_w2), 64'd0);
      check("abort_n_w3", 64'(n_w3), 64'd0);
      check("abort_n_b", 64'(n_b), 64'd0);
      check("abort_n_a1", 64'(n_a1), 64'd0);
      bif.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("abort_quiet", 64'(bif.out_valid), 64'd0);
      end
      bif.out_ready = 1'b0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < 4; j++)
            wm[i][j] = '0;
      model_exp();
      run_layer(32'd1, 32'd2, 32'd3, -1, 0, 1'b0, 1'b1, 1'b0);

      // randomized layers against the weight-file model
      for (int it = 0; it < 20; it++) begin
         int nw;
         nw = int'($urandom_range(0, 3));
         for (int q = 0; q < nw; q++)
            wr(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 3)), W'($urandom), 1'b1);
         model_exp();
         run_layer(W'($urandom), W'($urandom), W'($urandom), -1, 0, 1'b1, 1'b0, 1'b0);
      end

      // three-neuron instance: out-of-range neuron writes dropped, write+accept same cycle
      for (int s = 0; s < 4; s++) begin
         cfg_we3 = 1'b1; cfg_addr3 = 4'(3 * 4 + s); cfg_data3 = 32'd123;
         cyc();
      end
      cfg_we3 = 1'b1; cfg_addr3 = 4'(2 * 4 + 0); cfg_data3 = 32'd5;
      bif3.in_valid = 1'b1; bif3.in_a1 = 32'd1; bif3.in_a2 = 32'd2; bif3.in_a3 = 32'd3;
      cyc();
      cfg_we3 = 1'b0; bif3.in_valid = 1'b0;
      bif3.out_ready = 1'b1;
      got3 = 0; n3 = 0;
      while (got3 < 3 && n3 < 50) begin
         if (bif3.out_valid) begin
            check("n3_idx", 64'(bif3.out_idx), 64'(got3));
            check("n3_y", 64'(bif3.out_y), (got3 == 2) ? 64'd5 : 64'd0);
            check("n3_last", 64'(bif3.out_last), 64'(got3 == 2));
            got3++;
         end
         cyc();
         n3++;
      end
      check("n3_count", 64'(got3), 64'd3);
      check("n3_cycles", 64'(n3), 64'd6);
      check("n3_in_ready", 64'(bif3.in_ready), 64'd1);
      check("n3_out_valid", 64'(bif3.out_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/layer_ctrl.md
# layer_ctrl

Sequencer that time-multiplexes one `neuron_c` instance across all neurons of a fully connected 3-input layer. It sits directly upstream of the neuron. It owns the layer's weight/bias register file, latches one input vector per handshake, and steps a neuron index. For each index it drives the neuron's `a_*`, `w_*` and `b` ports, registers the neuron's `y`, and emits one result per neuron on a valid/ready output stream.

## Interface
- `WIDTH`, 32, data width of activations, weights, bias and result (signed).
- `N_NEURON`, 4, neurons in the layer (≥2).
- `IDX_W`, 2, index width; must satisfy 2^IDX_W ≥ N_NEURON.

Ports:
- `clk` input 1: sole clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `cfg_we` input 1: weight-file write strobe.
- `cfg_addr` input IDX_W+2: bits [IDX_W+1:2] select the neuron; bits [1:0] select the slot (0=w_1, 1=w_2, 2=w_3, 3=b).
- `cfg_data` input WIDTH: write data.
- `in_valid` input 1 / `in_ready` output 1: input vector handshake.
- `in_a1`, `in_a2`, `in_a3` input WIDTH: input activations.
- `n_a1`, `n_a2`, `n_a3` output WIDTH: to neuron `a_1..a_3`.
- `n_w1`, `n_w2`, `n_w3`, `n_b` output WIDTH: to neuron `w_1..w_3` and `b`.
- `n_y` input WIDTH: from neuron `y`.
- `out_valid` output 1 / `out_ready` input 1: result handshake.
- `out_y` output WIDTH: registered neuron result.
- `out_idx` output IDX_W: neuron index of `out_y`.
- `out_last` output 1: high with the result of neuron N_NEURON-1.

## Operation
- State machine with three states:
  - IDLE: `in_ready`=1. On `in_valid`, latch `in_a1..3` into the activation registers, set idx=0, go to RUN.
  - RUN: drive the weights of neuron idx. At the end of the cycle, capture `n_y` into `out_y`, capture idx into `out_idx`, set `out_last`=(idx==N_NEURON-1), set `out_valid`=1, go to OUT.
  - OUT: hold `out_valid` and all output registers until `out_ready`=1. On handshake, clear `out_valid`. If `out_last`, go to IDLE; otherwise increment idx and go to RUN.
- `n_a1..3` always equal the activation registers. `n_w1..3` and `n_b` are a combinational mux of the weight file at the current idx, in every state.
- Weight file: N_NEURON×4 registers of WIDTH bits.
  - A write takes effect only when `cfg_we`=1 and the state is IDLE.
  - Writes in RUN or OUT are dropped.
  - Writes whose neuron field is ≥ N_NEURON are dropped.
- If `cfg_we` and an input handshake occur in the same IDLE cycle, both take effect. The write is visible from the next cycle, before RUN samples it.
- No arithmetic in this block. Values pass through unchanged at WIDTH bits, signed.
- `in_ready` is 0 in RUN and OUT, so a new vector is never accepted mid-layer.

## Timing
- Reset values:
  - state = IDLE, idx = 0.
  - All activation registers and weight-file entries = 0.
  - `out_y` = 0, `out_idx` = 0, `out_valid` = 0, `out_last` = 0.
  - `in_ready` = 1 in the cycle after reset deasserts.
- Reset asserted mid-layer aborts the layer. No further `out_valid` occurs, and the weight file is cleared.
- Input accepted at edge k:
  - RUN for neuron 0 during cycle k..k+1.
  - `out_valid` rises after edge k+1.
- With `out_ready` held at 1:
  - One result every 2 cycles.
  - A full layer takes 2·N_NEURON cycles from accept to return to IDLE.
  - `in_ready` is high again the cycle after the last handshake.
- While `out_ready`=0, `out_valid`, `out_y`, `out_idx` and `out_last` are stable, and state remains OUT indefinitely.
- `n_y` is sampled only at the end of a RUN cycle. The neuron path must settle within one clock period.

## Test plan
- Reset, then poll outputs: `in_ready`=1, `out_valid`=0, all `n_w*`/`n_b`=0; a write in the reset cycle is lost.
- Load neuron 0 with w=(1,2,3), b=4 and neuron 3 with b=-7. Attach a stub where n_y = n_w1+n_w2+n_w3+n_b, apply in_a=(5,6,7), hold `out_ready`=1. Expect four results with `out_idx` 0,1,2,3 and `out_y` 10,0,0,-7. `out_last` is high only with idx 3. `in_ready` returns after 8 cycles.
- Same vector, with `out_ready` low for 5 cycles on the neuron-1 result: `out_valid`/`out_y`/`out_idx` stay frozen, no extra result, order preserved.
- `cfg_we` to neuron 2 slot 3 (b=99) issued during RUN: dropped, neuron 2 result unchanged. Repeated in IDLE: the next layer's idx-2 result reflects b=99.
- `cfg_we` with neuron field 3 while N_NEURON=3: no entry changes. Write and `in_valid` in the same IDLE cycle: the write is used by the layer.
- Assert `rst` in OUT of neuron 1: next cycle `out_valid`=0, `in_ready`=1, weights 0. Then a fresh vector produces idx 0 first.
